// File: rtl/alu4_seq_pkg.sv
// rtl/alu4_seq_pkg.sv - shared opcodes, FSM state encoding and flag ordering for alu4_acc_seq
package alu4_seq_pkg;

  // ALU opcodes, forwarded to the alu4 untouched
  localparam logic [2:0] OP_NOT_A = 3'b000;
  localparam logic [2:0] OP_NOT_B = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_SUB   = 3'b111;

  // 2'd3 is unused and falls back to idle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // flag vector layout {c,n,z,v}
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  function automatic flags_t load_flags(input logic [3:0] value);
    flags_t f;
    f         = '0;
    f[FLAG_N] = value[3];
    f[FLAG_Z] = (value == 4'd0);
    return f;
  endfunction

endpackage

// File: rtl/alu4_acc_seq.sv
// rtl/alu4_acc_seq.sv - accumulator command sequencer feeding a 4-bit ALU; ALU4_SEQ_STICKY_V_EN makes out_v sticky
module alu4_acc_seq
  import alu4_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_c,
  output logic             out_n,
  output logic             out_z,
  output logic             out_v,
  output logic [CNT_W-1:0] op_cnt
);

  state_t           state;
  logic [3:0]       acc;
  logic [3:0]       b_reg;
  logic [2:0]       op_reg;
  logic             load_reg;
  flags_t           flags;
  logic [CNT_W-1:0] cnt;
  logic             v_next;

  // overflow flag update for an ALU (non-load) command
`ifdef ALU4_SEQ_STICKY_V_EN
  assign v_next = flags[FLAG_V] | alu_v;
`else
  assign v_next = alu_v;
`endif

  // single FSM: command capture, accumulator/flag writeback, result handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      acc       <= 4'd0;
      b_reg     <= 4'd0;
      op_reg    <= 3'd0;
      load_reg  <= 1'b0;
      flags     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            b_reg    <= in_b;
            op_reg   <= in_op;
            load_reg <= in_load;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (load_reg) begin
            acc   <= b_reg;
            flags <= load_flags(b_reg);
          end else begin
            acc   <= alu_result;
            flags <= {alu_c, alu_n, alu_z, v_next};
          end
          cnt       <= cnt + 1'b1;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // operand a is the accumulator itself; b and op come from the captured command
  assign alu_a      = acc;
  assign alu_b      = b_reg;
  assign alu_op     = op_reg;
  assign out_result = acc;
  assign out_c      = flags[FLAG_C];
  assign out_n      = flags[FLAG_N];
  assign out_z      = flags[FLAG_Z];
  assign out_v      = flags[FLAG_V];
  assign op_cnt     = cnt;

endmodule

// File: tb/tb_alu4_acc_seq.sv
// tb/tb_alu4_acc_seq.sv - self-checking bench for alu4_acc_seq with an ALU stub and behavioural model
module tb_alu4_acc_seq;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_load = 1'b0;
  logic [2:0]       in_op = 3'd0;
  logic [3:0]       in_b = 4'd0;
  logic [3:0]       alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [3:0]       alu_result;
  logic             alu_c, alu_n, alu_z, alu_v;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_result;
  logic             out_c, out_n, out_z, out_v;
  logic [CNT_W-1:0] op_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu4_acc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_op(in_op), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_c(out_c), .out_n(out_n), .out_z(out_z), .out_v(out_v),
    .op_cnt(op_cnt)
  );

  // reference 4-bit ALU: returns {c,n,z,v,result}
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] wide;
    logic [3:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; wide = 5'd0;
    case (op)
      3'b000: r = ~a;
      3'b001: r = ~b;
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~(a ^ b);
      3'b110: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[3:0]; c = wide[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      default: begin
        wide = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = wide[3:0]; c = wide[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
    endcase
    return {c, r[3], (r == 4'd0), v, r};
  endfunction

  logic [7:0] stub;
  assign stub = alu_ref(alu_a, alu_b, alu_op);
  assign {alu_c, alu_n, alu_z, alu_v, alu_result} = stub;

  // behavioural model: 0 = accepting, 1 = executing, 2 = presenting result
  int         m_phase = 0;
  bit         model_live = 1'b0;
  logic [3:0] m_acc, m_b;
  logic [2:0] m_op;
  logic       m_load;
  logic [3:0] m_flags;
  int         m_count;
  logic [7:0] m_res;

  always @(posedge clk) begin
    model_live <= 1'b1;
    if (!reset_n) begin
      m_phase <= 0; m_acc <= 4'd0; m_b <= 4'd0; m_op <= 3'd0; m_load <= 1'b0;
      m_flags <= 4'd0; m_count <= 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_b <= in_b; m_op <= in_op; m_load <= in_load; m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (m_load) begin
        m_acc   <= m_b;
        m_flags <= {1'b0, m_b[3], (m_b == 4'd0), 1'b0};
      end else begin
        m_res = alu_ref(m_acc, m_b, m_op);
        m_acc <= m_res[3:0];
`ifdef ALU4_SEQ_STICKY_V_EN
        m_flags <= {m_res[7:5], m_res[4] | m_flags[0]};
`else
        m_flags <= m_res[7:4];
`endif
      end
      m_count <= (m_count + 1) % (1 << CNT_W);
      m_phase <= 2;
    end else begin
      if (out_ready) m_phase <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      check("in_ready", in_ready, m_phase == 0);
      check("out_valid", out_valid, m_phase == 2);
      check("out_result", out_result, m_acc);
      check("flags_cnzv", {out_c, out_n, out_z, out_v}, m_flags);
      check("op_cnt", op_cnt, m_count);
      check("alu_a", alu_a, m_acc);
      check("alu_b", alu_b, m_b);
      check("alu_op", alu_op, m_op);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  task automatic issue(input logic load, input logic [2:0] op, input logic [3:0] b);
    bit done;
    done = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_load = load; in_op = op; in_b = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic ack(input int hold);
    out_ready = 1'b0;
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic load, input logic [2:0] op, input logic [3:0] b);
    issue(load, op, b);
    wait_valid();
  endtask

  initial begin
    // reset with in_valid held high
    in_valid = 1'b1; in_load = 1'b1; in_b = 4'h5; in_op = 3'd2;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_cnt", op_cnt, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_flags", {out_c, out_n, out_z, out_v}, 0);
    reset_n = 1'b1;
    step();
    check("first_edge_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_valid();
    check("first_load", out_result, 4'h5);
    ack(0);

    // load 7, add 2
    do_reset(2);
    run_cmd(1'b1, 3'd0, 4'h7); ack(0);
    run_cmd(1'b0, 3'b110, 4'h2);
    check("add_result", out_result, 4'h9);
    check("add_flags", {out_c, out_n, out_z, out_v}, 4'b0101);
    check("add_cnt", op_cnt, 2);
    ack(0);

    // load 3, sub 3, hold out_ready low
    run_cmd(1'b1, 3'd0, 4'h3); ack(1);
    run_cmd(1'b0, 3'b111, 4'h3);
    for (int i = 0; i < 5; i++) begin
      check("sub_hold_result", out_result, 4'h0);
      check("sub_hold_valid", out_valid, 1);
      step();
    end
    check("sub_flags", {out_c, out_n, out_z, out_v}, 4'b1010);
    ack(0);

    // sticky overflow
    run_cmd(1'b1, 3'd0, 4'h7); ack(0);
    run_cmd(1'b0, 3'b110, 4'h1);
    check("sticky_add_v", out_v, 1);
    ack(0);
    run_cmd(1'b0, 3'b010, 4'hF);
    check("sticky_and_result", out_result, 4'h8);
`ifdef ALU4_SEQ_STICKY_V_EN
    check("sticky_and_v", out_v, 1);
`else
    check("sticky_and_v", out_v, 0);
`endif
    ack(0);
    run_cmd(1'b1, 3'd0, 4'h0);
    check("load_clears_v", out_v, 0);
    check("load_zero_z", out_z, 1);
    ack(0);

    // reset during EXEC
    issue(1'b1, 3'd0, 4'h9);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_acc", out_result, 0);
    check("midrst_cnt", op_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_pulse", out_valid, 0);
      step();
    end

    // counter wrap: 257 commands leaves op_cnt at 1
    for (int i = 0; i < 257; i++) begin
      run_cmd(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      ack(0);
    end
    check("cnt_wrap", op_cnt, 1);

    // randomized traffic with occasional mid-command reset
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
      issue(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 29) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else begin
        wait_valid();
        ack($urandom_range(0, 3));
      end
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
